cache_burst_sequencer: RTL and testbench
========================================

// Module: cache_burst_sequencer
// PURPOSE
//  CPU-facing front end of the cache; parametrised successor to the single-beat cache wrapper.
//  Accepts one read or write burst of 1..2^LEN_WIDTH words and turns it into single-word accesses.
//  Issues those accesses on the cache_ctrl req/rdy handshake, one word at a time.
//  New over the previous block: write bursts with per-beat data handshake, wrap-burst mode, and a last-beat flag.
// PARAMETERS
//  ADDR_WIDTH      10  byte-address width
//  DATA_WIDTH      32  word width; multiple of 8; BPW = DATA_WIDTH/8 (power of 2)
//  LEN_WIDTH       8   burst length field width; beats = i_len+1
//  LINE_SIZE_BITS  4   log2 bytes per cache line; wrap boundary
// PORTS
//  clk         in   1      clock
//  reset_n     in   1      synchronous, active-low reset
//  i_req       in   1      burst request, sampled only when o_rdy=1
//  i_addr      in   ADDR   start byte address; low log2(BPW) bits ignored (forced to 0)
//  i_wen       in   1      1=write burst, 0=read burst
//  i_ben       in   BPW    byte enables, applied to every write beat
//  i_len       in   LEN    beats-1
//  i_wrap      in   1      1=wrap within the aligned line, 0=incrementing
//  i_wdata     in   DATA   write beat data
//  i_wvalid    in   1      write beat valid
//  o_wready    out  1      write beat accepted when i_wvalid&o_wready
//  o_rvalid    out  1      one-cycle read beat pulse
//  o_rdata     out  DATA   read beat data; 0 when o_rvalid=0
//  o_rlast     out  1      high with o_rvalid on the final read beat
//  o_rdy       out  1      idle, ready for a new burst
//  o_cc_req    out  1      word request to cache_ctrl
//  o_cc_addr   out  ADDR   word-aligned byte address
//  o_cc_wen    out  1      word write
//  o_cc_ben    out  BPW    byte enables
//  o_cc_wdata  out  DATA   write data
//  i_cc_rdata  in   DATA   read data; valid when i_cc_rdy re-asserts after ack
//  i_cc_rdy    in   1      cache_ctrl idle; falls to acknowledge o_cc_req
// BEHAVIOUR
//  Reset values: o_rdy=1; all other outputs 0; state IDLE; beat counter 0.
//  Reset taken mid-burst: abort at the next edge, drop o_cc_req, emit no further beats.
//  All outputs are registered.
//  IDLE: if i_req:
//   - latch addr (aligned), wen, ben, len, wrap; o_rdy<=0; beat<=0.
//   - next state is WDATA if wen, else ISSUE.
//  WDATA: o_wready=1 (combinational from state).
//   - On i_wvalid: latch i_wdata into o_cc_wdata, go to ISSUE.
//   - No beat is issued before its data is accepted.
//  ISSUE: hold o_cc_req=0 until i_cc_rdy=1, then assert o_cc_req, go to ACK.
//  ACK: hold o_cc_req=1 with addr/wen/ben/wdata stable until i_cc_rdy=0.
//   - On i_cc_rdy=0: o_cc_req<=0, go to DONE.
//  DONE: wait for i_cc_rdy=1; the access is then complete.
//   - Read: o_rvalid<=1, o_rdata<=i_cc_rdata, o_rlast<=(beat==len).
//   - If beat==len: o_rdy<=1, go to IDLE.
//   - Else: beat++, advance addr, go to WDATA (write) or ISSUE (read).
//  Read beat latency: o_rvalid is 1 cycle after the i_cc_rdy rise in DONE.
//  Burst end: o_rdy rises in the same cycle as the final o_rvalid.
//  Address advance: next = addr+BPW, modulo 2^ADDR_WIDTH (top-of-space wrap is legal).
//  Wrap mode:
//   - The upper ADDR_WIDTH-LINE_SIZE_BITS bits are held; only the in-line offset increments, mod 2^LINE_SIZE_BITS.
//   - Bursts longer than one line keep wrapping in the same line.
//  len=0: exactly one beat; o_rlast on that beat.
//  len=max (2^LEN_WIDTH-1): 2^LEN_WIDTH beats; the counter is LEN_WIDTH bits and never overflows.
//  i_req while o_rdy=0 is ignored (not queued). CPU inputs other than i_wdata/i_wvalid are ignored mid-burst.
//  i_cc_rdy already 0 on entering ISSUE: stall in ISSUE; no request is issued.
// STRUCTURE
//  Shared package cache_pkg:
//   - state enum (IDLE, WDATA, ISSUE, ACK, DONE).
//   - BPW/offset-width localparam functions.
//   - next_addr(addr, wrap) function.
//  Single flat module; no sub-module. cache_ctrl is instantiated by the parent, not inside this block.
// TESTING
//  T1 Read, addr=0x040, len=3, incr, cc model 2-cycle ack:
//   -> cc addrs 0x040,0x044,0x048,0x04C; 4 o_rvalid pulses, rlast on the 4th; o_rdy back 1.
//  T2 Wrap read, LINE_SIZE_BITS=4, addr=0x038, len=3:
//   -> cc addrs 0x038,0x03C,0x030,0x034.
//  T3 Write, addr=0x100, len=2, ben=4'b0011, wvalid gapped 3 cycles between beats:
//   -> 3 cc writes at 0x100/0x104/0x108 with matching data; no req while waiting on wvalid.
//  T4 len=0 read, i_cc_rdy low for 5 cycles at request time:
//   -> stall in ISSUE with o_cc_req=0, then 1 beat with rlast=1.
//  T5 Read, addr=0x3FC, incr, len=1, ADDR_WIDTH=10:
//   -> second addr 0x000.
//  T6 Reset during ACK of beat 2/4; i_req pulses while busy:
//   -> next cycle o_cc_req=0, o_rdy=1, no o_rvalid; busy-time i_req has no effect.

Source files
------------

// File: rtl/cache_pkg.sv
// Package: cache_pkg
// Shared types and helpers for the cache front-end blocks.
//   state_t    : burst sequencer FSM states
//   bpw_of     : bytes per word for a given data width
//   off_width  : byte-offset bits within a word
//   next_addr  : word address advance, incrementing or wrapping within a line
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    ISSUE,
    ACK,
    DONE
  } state_t;

  function automatic int unsigned bpw_of(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned off_width(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  // Works on a 32-bit container so callers of any address width up to 32 can
  // share it; the result is already reduced modulo 2^addr_width.
  function automatic logic [31:0] next_addr(
    input logic [31:0] addr,
    input logic        wrap,
    input int unsigned bpw,
    input int unsigned line_bits,
    input int unsigned addr_width
  );
    logic [31:0] line_mask;
    logic [31:0] addr_mask;
    logic [31:0] incr;
    logic [31:0] res;
    line_mask = (32'd1 << line_bits) - 32'd1;
    addr_mask = (addr_width >= 32) ? '1 : ((32'd1 << addr_width) - 32'd1);
    incr      = addr + bpw;
    if (wrap) res = (addr & ~line_mask) | (incr & line_mask);
    else      res = incr;
    return res & addr_mask;
  endfunction

endpackage

// File: rtl/cache_burst_sequencer.sv
// Module: cache_burst_sequencer
// CPU-facing cache front end. Accepts one read or write burst of i_len+1
// words and issues it to cache_ctrl as single-word req/rdy transactions.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   i_req/i_addr/i_wen/i_ben/i_len/i_wrap   burst request (taken when o_rdy=1)
//   i_wdata/i_wvalid/o_wready               per-beat write data handshake
//   o_rvalid/o_rdata/o_rlast                read beat output (one-cycle pulse)
//   o_rdy                                   idle, ready for a new burst
//   o_cc_req/o_cc_addr/o_cc_wen/o_cc_ben/o_cc_wdata  word request to cache_ctrl
//   i_cc_rdata/i_cc_rdy                     cache_ctrl read data / idle-ack
module cache_burst_sequencer
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned LEN_WIDTH      = 8,
  parameter int unsigned LINE_SIZE_BITS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic                    i_wen,
  input  logic [DATA_WIDTH/8-1:0] i_ben,
  input  logic [LEN_WIDTH-1:0]    i_len,
  input  logic                    i_wrap,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  output logic                    o_rvalid,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic                    o_rlast,
  output logic                    o_rdy,
  output logic                    o_cc_req,
  output logic [ADDR_WIDTH-1:0]   o_cc_addr,
  output logic                    o_cc_wen,
  output logic [DATA_WIDTH/8-1:0] o_cc_ben,
  output logic [DATA_WIDTH-1:0]   o_cc_wdata,
  input  logic [DATA_WIDTH-1:0]   i_cc_rdata,
  input  logic                    i_cc_rdy
);

  localparam int unsigned BPW  = bpw_of(DATA_WIDTH);
  localparam int unsigned OFFW = off_width(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((1 << OFFW) - 1);

  state_t                state, state_nxt;
  logic [LEN_WIDTH-1:0]  beat;
  logic [LEN_WIDTH-1:0]  len_q;
  logic                  wrap_q;
  logic                  last_beat;
  logic [ADDR_WIDTH-1:0] addr_adv;

  // o_cc_addr doubles as the burst address register.
  always_comb begin
    last_beat = (beat == len_q);
    addr_adv  = ADDR_WIDTH'(next_addr(32'(o_cc_addr), wrap_q, BPW,
                                      LINE_SIZE_BITS, ADDR_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_req) state_nxt = i_wen ? WDATA : ISSUE;
      WDATA:   if (i_wvalid) state_nxt = ISSUE;
      ISSUE:   if (i_cc_rdy) state_nxt = ACK;
      ACK:     if (!i_cc_rdy) state_nxt = DONE;
      DONE: begin
        if (i_cc_rdy) begin
          if (last_beat)     state_nxt = IDLE;
          else if (o_cc_wen) state_nxt = WDATA;
          else               state_nxt = ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_wready = (state == WDATA);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_rvalid   <= 1'b0;
      o_rdata    <= '0;
      o_rlast    <= 1'b0;
      o_rdy      <= 1'b1;
      o_cc_req   <= 1'b0;
      o_cc_addr  <= '0;
      o_cc_wen   <= 1'b0;
      o_cc_ben   <= '0;
      o_cc_wdata <= '0;
      beat       <= '0;
      len_q      <= '0;
      wrap_q     <= 1'b0;
    end else begin
      o_rvalid <= 1'b0;
      o_rlast  <= 1'b0;
      o_rdata  <= '0;
      case (state)
        IDLE: begin
          if (i_req) begin
            o_cc_addr <= i_addr & ALIGN_MASK;
            o_cc_wen  <= i_wen;
            o_cc_ben  <= i_ben;
            len_q     <= i_len;
            wrap_q    <= i_wrap;
            beat      <= '0;
            o_rdy     <= 1'b0;
          end
        end
        WDATA: if (i_wvalid) o_cc_wdata <= i_wdata;
        ISSUE: if (i_cc_rdy) o_cc_req <= 1'b1;
        ACK:   if (!i_cc_rdy) o_cc_req <= 1'b0;
        DONE: begin
          if (i_cc_rdy) begin
            if (!o_cc_wen) begin
              o_rvalid <= 1'b1;
              o_rdata  <= i_cc_rdata;
              o_rlast  <= last_beat;
            end
            if (last_beat) begin
              o_rdy <= 1'b1;
            end else begin
              beat      <= beat + LEN_WIDTH'(1);
              o_cc_addr <= addr_adv;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_burst_sequencer.sv
module tb_cache_burst_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req;
  logic [9:0]  i_addr;
  logic        i_wen;
  logic [3:0]  i_ben;
  logic [7:0]  i_len;
  logic        i_wrap;
  logic [31:0] i_wdata;
  logic        i_wvalid;
  logic        o_wready;
  logic        o_rvalid;
  logic [31:0] o_rdata;
  logic        o_rlast;
  logic        o_rdy;
  logic        o_cc_req;
  logic [9:0]  o_cc_addr;
  logic        o_cc_wen;
  logic [3:0]  o_cc_ben;
  logic [31:0] o_cc_wdata;
  logic [31:0] i_cc_rdata;
  logic        i_cc_rdy;

  always #5 clk = ~clk;

  cache_burst_sequencer #(
    .ADDR_WIDTH(10), .DATA_WIDTH(32), .LEN_WIDTH(8), .LINE_SIZE_BITS(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_wen(i_wen), .i_ben(i_ben),
    .i_len(i_len), .i_wrap(i_wrap), .i_wdata(i_wdata), .i_wvalid(i_wvalid),
    .o_wready(o_wready), .o_rvalid(o_rvalid), .o_rdata(o_rdata),
    .o_rlast(o_rlast), .o_rdy(o_rdy),
    .o_cc_req(o_cc_req), .o_cc_addr(o_cc_addr), .o_cc_wen(o_cc_wen),
    .o_cc_ben(o_cc_ben), .o_cc_wdata(o_cc_wdata),
    .i_cc_rdata(i_cc_rdata), .i_cc_rdy(i_cc_rdy)
  );

  int vectors = 0;
  int miscompares = 0;

  // Word-addressed backing store of the cache_ctrl model
  logic [31:0] mem [256];

  // cache_ctrl model controls and transaction log
  int unsigned ack_dly  = 0;
  int unsigned busy_cyc = 1;
  logic        hold_low = 1'b0;
  logic [9:0]  txq_addr[$];
  logic        txq_wen[$];
  logic [3:0]  txq_ben[$];
  logic [31:0] txq_wdata[$];
  logic [31:0] rvq_data[$];
  logic        rvq_last[$];

  // Expected burst contents
  logic [9:0]  exp_addr_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] exp_wd_q[$];

  int          sl_phase = 0;
  int unsigned sl_cnt   = 0;
  logic        sl_wen   = 1'b0;
  logic [9:0]  sl_addr  = '0;
  logic        sl_exp_rv = 1'b0;
  logic [31:0] sl_exp_data = '0;

  // cache_ctrl model: acknowledges a request by dropping rdy, stays busy,
  // then re-raises rdy with read data.
  initial begin
    i_cc_rdy   = 1'b1;
    i_cc_rdata = '0;
    forever begin
      @(negedge clk);
      if (sl_exp_rv) begin
        vectors++;
        if (o_rvalid !== 1'b1 || o_rdata !== sl_exp_data) begin
          miscompares++;
          $display("FAIL rvalid_latency: got rvalid=%0b rdata=%h, want 1 %h",
                   o_rvalid, o_rdata, sl_exp_data);
        end
        sl_exp_rv = 1'b0;
      end
      if (!reset_n) begin
        sl_phase = 0;
        i_cc_rdy = 1'b1;
      end else begin
        case (sl_phase)
          0: begin
            i_cc_rdy = !hold_low;
            if (o_cc_req === 1'b1 && !hold_low) begin
              txq_addr.push_back(o_cc_addr);
              txq_wen.push_back(o_cc_wen);
              txq_ben.push_back(o_cc_ben);
              txq_wdata.push_back(o_cc_wdata);
              sl_wen  = o_cc_wen;
              sl_addr = o_cc_addr;
              if (o_cc_wen)
                for (int k = 0; k < 4; k++)
                  if (o_cc_ben[k]) mem[o_cc_addr[9:2]][8*k +: 8] = o_cc_wdata[8*k +: 8];
              if (ack_dly == 0) begin
                i_cc_rdy = 1'b0;
                sl_phase = 2;
                sl_cnt   = busy_cyc;
              end else begin
                sl_phase = 1;
                sl_cnt   = ack_dly;
              end
            end
          end
          1: begin
            vectors++;
            if (o_cc_req !== 1'b1 || o_cc_addr !== sl_addr) begin
              miscompares++;
              $display("FAIL ack_hold: got req=%0b addr=%h, want 1 %h", o_cc_req, o_cc_addr, sl_addr);
            end
            sl_cnt--;
            if (sl_cnt == 0) begin
              i_cc_rdy = 1'b0;
              sl_phase = 2;
              sl_cnt   = busy_cyc;
            end
          end
          default: begin
            i_cc_rdata = $urandom;
            sl_cnt--;
            if (sl_cnt == 0) begin
              i_cc_rdy = 1'b1;
              sl_phase = 0;
              if (!sl_wen) begin
                i_cc_rdata  = mem[sl_addr[9:2]];
                sl_exp_rv   = 1'b1;
                sl_exp_data = i_cc_rdata;
              end
            end
          end
        endcase
      end
    end
  end

  // Read-beat monitor; outside a beat the read outputs must be zero.
  initial begin
    forever begin
      @(negedge clk);
      if (o_rvalid === 1'b1) begin
        rvq_data.push_back(o_rdata);
        rvq_last.push_back(o_rlast);
      end else begin
        vectors++;
        if (o_rdata !== 32'h0 || o_rlast !== 1'b0) begin
          miscompares++;
          $display("FAIL idle_rdata: got rdata=%h rlast=%0b, want 0 0", o_rdata, o_rlast);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  // Address of beat i from the burst rules, in closed form
  function automatic logic [9:0] beat_addr(input logic [9:0] base, input logic wrap,
                                           input int unsigned i);
    int unsigned b, r;
    logic [31:0] rv;
    b = 32'(base) & 32'hFFFF_FFFC;
    if (wrap) r = (b & 32'hFFFF_FFF0) + ((b + 4*i) % 16);
    else      r = (b + 4*i) % 1024;
    rv = r;
    return rv[9:0];
  endfunction

  task automatic clear_logs();
    txq_addr.delete(); txq_wen.delete(); txq_ben.delete(); txq_wdata.delete();
    rvq_data.delete(); rvq_last.delete();
  endtask

  task automatic build_exp(input logic [9:0] a, input logic wr, input int unsigned len);
    logic [9:0] ea;
    exp_addr_q.delete(); exp_rd_q.delete(); exp_wd_q.delete();
    for (int unsigned i = 0; i <= len; i++) begin
      ea = beat_addr(a, wr, i);
      exp_addr_q.push_back(ea);
      exp_rd_q.push_back(mem[ea[9:2]]);
      exp_wd_q.push_back($urandom);
    end
  endtask

  task automatic issue_req(input logic [9:0] a, input logic w, input logic [3:0] be,
                           input int unsigned len, input logic wr);
    i_req = 1'b1; i_addr = a; i_wen = w; i_ben = be; i_len = 8'(len); i_wrap = wr;
    @(negedge clk);
    i_req = 1'b0; i_addr = 10'($urandom); i_wen = 1'($urandom);
    i_ben = 4'($urandom); i_len = 8'($urandom); i_wrap = 1'($urandom);
    vectors++;
    if (o_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL accept: got o_rdy=%0b, want 0", o_rdy);
    end
  endtask

  task automatic wait_rdy(input string name);
    int t = 0;
    while (o_rdy !== 1'b1 && t < 10000) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (o_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_timeout: got o_rdy=%0b, want 1", name, o_rdy);
    end
  endtask

  task automatic check_burst(input string name, input logic w, input logic [3:0] be,
                             input int unsigned nb);
    int unsigned n;
    vectors++;
    if (txq_addr.size() != nb) begin
      miscompares++;
      $display("FAIL %s_req_count: got %0d, want %0d", name, txq_addr.size(), nb);
    end
    n = (txq_addr.size() < nb) ? txq_addr.size() : nb;
    for (int unsigned i = 0; i < n; i++) begin
      vectors++;
      if (txq_addr[i] !== exp_addr_q[i] || txq_wen[i] !== w || txq_ben[i] !== be ||
          (w && txq_wdata[i] !== exp_wd_q[i])) begin
        miscompares++;
        $display("FAIL %s_req%0d: got a=%h w=%0b be=%h d=%h, want a=%h w=%0b be=%h d=%h",
                 name, i, txq_addr[i], txq_wen[i], txq_ben[i], txq_wdata[i],
                 exp_addr_q[i], w, be, w ? exp_wd_q[i] : txq_wdata[i]);
      end
    end
    vectors++;
    if (rvq_data.size() != (w ? 0 : nb)) begin
      miscompares++;
      $display("FAIL %s_beat_count: got %0d, want %0d", name, rvq_data.size(), w ? 0 : nb);
    end else if (!w) begin
      for (int unsigned i = 0; i < nb; i++) begin
        vectors++;
        if (rvq_data[i] !== exp_rd_q[i] || rvq_last[i] !== (i == nb - 1)) begin
          miscompares++;
          $display("FAIL %s_beat%0d: got d=%h last=%0b, want d=%h last=%0b",
                   name, i, rvq_data[i], rvq_last[i], exp_rd_q[i], (i == nb - 1));
        end
      end
    end
  endtask

  task automatic run_burst(input string name, input logic [9:0] a, input logic w,
                           input logic [3:0] be, input int unsigned len, input logic wr,
                           input int unsigned gap);
    int t;
    clear_logs();
    build_exp(a, wr, len);
    issue_req(a, w, be, len, wr);
    if (w) begin
      for (int unsigned b = 0; b <= len; b++) begin
        t = 0;
        while (o_wready !== 1'b1 && t < 2000) begin
          @(negedge clk);
          t++;
        end
        vectors++;
        if (o_wready !== 1'b1 || txq_addr.size() != b) begin
          miscompares++;
          $display("FAIL %s_wready%0d: got wready=%0b reqs=%0d, want 1 %0d",
                   name, b, o_wready, txq_addr.size(), b);
        end
        for (int unsigned g = 0; g < gap; g++) begin
          vectors++;
          if (o_cc_req !== 1'b0 || o_wready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_wait_data: got req=%0b wready=%0b, want 0 1",
                     name, o_cc_req, o_wready);
          end
          @(negedge clk);
        end
        i_wvalid = 1'b1;
        i_wdata  = exp_wd_q[b];
        @(negedge clk);
        i_wvalid = 1'b0;
        i_wdata  = $urandom;
      end
    end
    wait_rdy(name);
    vectors++;
    if (o_rvalid !== !w || o_rlast !== !w) begin
      miscompares++;
      $display("FAIL %s_end: got rvalid=%0b rlast=%0b with rdy, want %0b %0b",
               name, o_rvalid, o_rlast, !w, !w);
    end
    @(negedge clk);
    check_burst(name, w, be, len + 1);
  endtask

  task automatic check_lit(input string name, input logic [9:0] lit[4], input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      vectors++;
      if (i >= txq_addr.size() || txq_addr[i] !== lit[i]) begin
        miscompares++;
        $display("FAIL %s_addr%0d: got %h, want %h", name, i,
                 (i < txq_addr.size()) ? txq_addr[i] : 10'h3FF, lit[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (o_rdy !== 1'b1) begin
      miscompares++; $display("FAIL reset_rdy: got %0b, want 1", o_rdy);
    end
    vectors++;
    if ({o_rvalid, o_rlast, o_cc_req, o_cc_wen, o_wready} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got rv=%0b rl=%0b req=%0b wen=%0b wr=%0b, want 0s",
               o_rvalid, o_rlast, o_cc_req, o_cc_wen, o_wready);
    end
    vectors++;
    if (o_rdata !== 32'h0 || o_cc_addr !== 10'h0 || o_cc_ben !== 4'h0 || o_cc_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: got rd=%h a=%h be=%h wd=%h, want 0s",
               o_rdata, o_cc_addr, o_cc_ben, o_cc_wdata);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_incr_read();
    logic [9:0] lit[4] = '{10'h040, 10'h044, 10'h048, 10'h04C};
    ack_dly = 1; busy_cyc = 2;
    run_burst("t1_incr", 10'h040, 1'b0, 4'hF, 3, 1'b0, 0);
    check_lit("t1_incr", lit, 4);
  endtask

  task automatic test_wrap_read();
    logic [9:0] lit[4] = '{10'h038, 10'h03C, 10'h030, 10'h034};
    ack_dly = 0; busy_cyc = 1;
    run_burst("t2_wrap", 10'h038, 1'b0, 4'hF, 3, 1'b1, 0);
    check_lit("t2_wrap", lit, 4);
  endtask

  task automatic test_write();
    logic [9:0] lit[4] = '{10'h100, 10'h104, 10'h108, 10'h000};
    ack_dly = 1; busy_cyc = 1;
    run_burst("t3_write", 10'h100, 1'b1, 4'b0011, 2, 1'b0, 3);
    check_lit("t3_write", lit, 3);
  endtask

  task automatic test_len0_stall();
    ack_dly = 0; busy_cyc = 2;
    hold_low = 1'b1;
    repeat (2) @(negedge clk);
    clear_logs();
    build_exp(10'h050, 1'b0, 0);
    issue_req(10'h050, 1'b0, 4'hF, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (o_cc_req !== 1'b0 || o_rdy !== 1'b0) begin
        miscompares++;
        $display("FAIL t4_stall: got req=%0b rdy=%0b, want 0 0", o_cc_req, o_rdy);
      end
      @(negedge clk);
    end
    hold_low = 1'b0;
    wait_rdy("t4_len0");
    @(negedge clk);
    check_burst("t4_len0", 1'b0, 4'hF, 1);
  endtask

  task automatic test_top_of_space();
    logic [9:0] lit[4] = '{10'h3FC, 10'h000, 10'h000, 10'h000};
    ack_dly = 0; busy_cyc = 1;
    run_burst("t5_top", 10'h3FD, 1'b0, 4'hF, 1, 1'b0, 0);
    check_lit("t5_top", lit, 2);
  endtask

  task automatic test_reset_midburst();
    int t = 0;
    logic [31:0] d0;
    ack_dly = 6; busy_cyc = 1;
    clear_logs();
    d0 = mem[10'h200 >> 2];
    issue_req(10'h200, 1'b0, 4'hF, 3, 1'b0);
    while (!(txq_addr.size() == 2 && o_cc_req === 1'b1) && t < 500) begin
      i_req  = 1'($urandom_range(0, 1));
      i_addr = 10'h080;
      i_wen  = 1'b1;
      @(negedge clk);
      t++;
    end
    i_req = 1'b0;
    vectors++;
    if (t >= 500) begin
      miscompares++; $display("FAIL t6_reach_ack: got timeout, want beat 2 in ACK");
    end
    reset_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (o_cc_req !== 1'b0 || o_rdy !== 1'b1 || o_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL t6_abort: got req=%0b rdy=%0b rv=%0b, want 0 1 0", o_cc_req, o_rdy, o_rvalid);
    end
    @(negedge clk);
    reset_n = 1'b1;
    ack_dly = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if (o_cc_req !== 1'b0 || o_rvalid !== 1'b0 || o_rdy !== 1'b1) begin
        miscompares++;
        $display("FAIL t6_quiet: got req=%0b rv=%0b rdy=%0b, want 0 0 1", o_cc_req, o_rvalid, o_rdy);
      end
    end
    vectors++;
    if (txq_addr.size() != 2 || txq_addr[0] !== 10'h200 || txq_addr[1] !== 10'h204) begin
      miscompares++;
      $display("FAIL t6_reqs: got %0d reqs, want 2 at 200/204", txq_addr.size());
    end
    vectors++;
    if (rvq_data.size() != 1 || rvq_data[0] !== d0 || rvq_last[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL t6_beats: got %0d beats, want 1 with d=%h last=0", rvq_data.size(), d0);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 20; n++) begin
      ack_dly  = $urandom_range(0, 2);
      busy_cyc = $urandom_range(1, 3);
      run_burst("rand", 10'($urandom), 1'($urandom), 4'($urandom),
                $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 3));
    end
    ack_dly = 0; busy_cyc = 1;
    run_burst("max_wrap_rd", 10'h2E4, 1'b0, 4'hF, 255, 1'b1, 0);
    run_burst("max_incr_wr", 10'h3F0, 1'b1, 4'b1010, 255, 1'b0, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    i_req = 1'b0; i_addr = '0; i_wen = 1'b0; i_ben = '0; i_len = '0; i_wrap = 1'b0;
    i_wdata = '0; i_wvalid = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    test_reset();
    test_incr_read();
    test_wrap_read();
    test_write();
    test_len0_stall();
    test_top_of_space();
    test_reset_midburst();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
